piso_tx_scheduler: RTL and testbench
====================================

# piso_tx_scheduler

Sequences and shares the 32-bit parallel-in/serial-out shifter between up to NREQ requesters on the tcclock domain. Round-robin arbitrates pending 32-bit words, drives the shifter's `din`/`load`/`reset`, tracks the 32 serial bit times, and returns per-requester ack/done pulses. Sits in the top module between the slave-register requesters and the shifter instance, whose `dout` is the serial line.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `clk_out` in, 1: tcclock; all logic on the rising edge.
- `reset` in, 1: asynchronous, active-low global reset.
- `en` in, 1: 1 = new grants allowed; 0 = no new grants, current frame completes.
- `req_valid` in, NREQ: requester i has a word pending.
- `req_data` in, 32*NREQ: word i at `[32*i+31:32*i]`, held stable while `req_valid[i]`=1 and until ack.
- `req_ack` out, NREQ: one-cycle pulse; word i captured.
- `req_done` out, NREQ: one-cycle pulse during the last bit time of word i.
- `piso_din` out, 32: to shifter `din`.
- `piso_load` out, 1: to shifter `load`.
- `piso_clr` out, 1: to shifter synchronous active-high `reset`.
- `tx_valid` out, 1: shifter `dout` carries a frame bit this cycle.
- `tx_last` out, 1: current bit is bit 0.
- `bit_cnt` out, 5: index of the bit on `dout`, 31 down to 0.
- `grant` out, NREQ: one-hot owner of the current frame; held from the LOAD state through the last bit.
- `busy` out, 1: state != IDLE.

## Operation
- States: IDLE, LOAD, SHIFT.
- IDLE: if `en`=1 and any `req_valid`, pick the winner round-robin, searching upward from `rr_ptr` with wrap. At that edge, register `grant`, `piso_din`=winner's word, `piso_load`=1, `req_ack[winner]`=1, and set `rr_ptr`=winner+1 mod NREQ. Go to LOAD.
- LOAD: lasts one cycle; the shifter captures `piso_din`. Next state SHIFT, `bit_cnt`=31, `tx_valid`=1, `piso_load`=0, `req_ack`=0.
- SHIFT: `bit_cnt` decrements by one per cycle. When `bit_cnt`=0, `tx_last`=1 and `req_done[grant]`=1. The next edge goes to IDLE: `tx_valid`=0, `grant`=0.
- `req_valid` is sampled only at arbitration points. A requester drops `req_valid` within 31 cycles of ack, or keeps it high to offer its next word.
- `en` falling mid-frame does not truncate the frame; it only blocks the next grant.
- `piso_clr` is 1 during reset and clears at the first `clk_out` edge after `reset` deasserts.
- Reset mid-frame: all outputs go to reset values immediately. The shifter clears at the next edge through `piso_clr`. The partial frame is dropped with no `req_done`.

## Timing
- Reset values: `piso_din`=0, `piso_load`=0, `piso_clr`=1, `tx_valid`=0, `tx_last`=0, `bit_cnt`=0, `grant`=0, `req_ack`=0, `req_done`=0, `busy`=0, `rr_ptr`=0.
- Edge E0 (IDLE, request seen): `req_ack` and `piso_load` are high in cycle E0..E1.
- Edge E1: shifter loads. Bit 31 appears on `dout` in cycle E1..E2, and bit 0 in cycle E32..E33.
- A frame occupies 32 `tx_valid` cycles.
- Latency from a `req_valid` sampled at E0 to the first serial bit is 1 cycle after the LOAD cycle.
- Without back-to-back mode, the minimum gap between frames is 2 `tx_valid`=0 cycles (IDLE, LOAD).
- Simultaneous `req_valid` from all requesters: grants rotate in the order i, i+1, …, wrapping at NREQ-1 to 0.

## Configuration
- `PISO_SCHED_B2B_EN` defined: arbitration is also performed at the edge entering `bit_cnt`=0.
  - If a winner exists, `piso_load`, `piso_din` and `req_ack` are asserted during the last-bit cycle, concurrent with `tx_valid`/`tx_last`/`req_done`.
  - The FSM then goes SHIFT→SHIFT with `bit_cnt`=31 and `grant` updated, giving zero gap between frames.
  - If there is no winner, behaviour is as without the macro.
- `PISO_SCHED_B2B_EN` undefined: every frame returns through IDLE and LOAD.

## Test plan
- Reset release, then req0 with data 0xA5A5_0F0F: `req_ack[0]` 1 cycle after sampling; `dout` serialises 1,0,1,0,… MSB-first over 32 `tx_valid` cycles; `req_done[0]` with `bit_cnt`=0.
- `req_valid`=4'b1111 held, NREQ=4: grant order 0,1,2,3,0; 2-cycle gaps without the macro; zero gaps with `PISO_SCHED_B2B_EN`.
- `en`=0 asserted at `bit_cnt`=10 with req1 pending: frame completes, no further ack, `busy`=0. `en`=1 → req1 granted.
- `reset` low at `bit_cnt`=15: outputs take reset values immediately, `piso_clr`=1; after release, the shifter clears, `rr_ptr`=0, no `req_done`.
- req2 alone for 3 words, then req0 arrives: req0 granted next (pointer at 3 wraps to 0), and `rr_ptr` becomes 1.

Source files
------------

// File: rtl/piso_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : piso_tx_scheduler
// Purpose  : Round-robin scheduler that shares one 32-bit parallel-in /
//            serial-out shifter between NREQ requesters on the tcclock
//            domain. It loads the winning word into the shifter, tracks the
//            32 serial bit times and returns per-requester ack/done pulses.
// Option   : `define PISO_SCHED_B2B_EN to arbitrate again on the edge that
//            enters the last bit, so that back-to-back frames have no gap.
// Ports    :
//   clk_out    in   tcclock; all logic on the rising edge
//   reset      in   asynchronous active-low reset
//   en         in   1 = new grants allowed (a running frame always completes)
//   req_valid  in   [NREQ]     requester i has a word pending
//   req_data   in   [32*NREQ]  word i at [32*i+31:32*i]
//   req_ack    out  [NREQ]     one-cycle pulse: word i captured
//   req_done   out  [NREQ]     one-cycle pulse during the last bit of word i
//   piso_din   out  [32]       shifter parallel data
//   piso_load  out             shifter load strobe
//   piso_clr   out             shifter synchronous clear
//   tx_valid   out             shifter dout carries a frame bit
//   tx_last    out             current bit is bit 0
//   bit_cnt    out  [5]        index of the bit on dout (31 down to 0)
//   grant      out  [NREQ]     one-hot owner of the current frame
//   busy       out             scheduler is not idle
// Revision : 1.0 - initial release
// ============================================================================
module piso_tx_scheduler #(
  parameter int NREQ = 4
) (
  input  logic                 clk_out,
  input  logic                 reset,
  input  logic                 en,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      req_done,
  output logic [31:0]          piso_din,
  output logic                 piso_load,
  output logic                 piso_clr,
  output logic                 tx_valid,
  output logic                 tx_last,
  output logic [4:0]           bit_cnt,
  output logic [NREQ-1:0]      grant,
  output logic                 busy
);

  localparam int PW = $clog2(NREQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;

  logic [1:0]      r_state;
  logic [PW-1:0]   r_rr_ptr;

  logic            w_win_any;
  logic [NREQ-1:0] w_win_oh;
  logic [31:0]     w_win_data;
  logic [PW-1:0]   w_next_ptr;

`ifdef PISO_SCHED_B2B_EN
  // Winner picked during the last bit of a frame; it takes ownership on the
  // following edge so that req_done of the finishing frame uses the old grant.
  logic [NREQ-1:0] r_next_grant;
  logic            r_chain;
`endif

  // Round-robin search upward from the pointer with wrap; first hit wins.
  always_comb begin
    w_win_any  = 1'b0;
    w_win_oh   = '0;
    w_win_data = '0;
    w_next_ptr = r_rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(r_rr_ptr) + k) % NREQ;
      if (!w_win_any && req_valid[idx]) begin
        w_win_any     = 1'b1;
        w_win_oh[idx] = 1'b1;
        w_win_data    = req_data[32*idx +: 32];
        w_next_ptr    = PW'((idx + 1) % NREQ);
      end
    end
  end

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      piso_din  <= '0;
      piso_load <= 1'b0;
      piso_clr  <= 1'b1;
      tx_valid  <= 1'b0;
      tx_last   <= 1'b0;
      bit_cnt   <= '0;
      grant     <= '0;
      req_ack   <= '0;
      req_done  <= '0;
`ifdef PISO_SCHED_B2B_EN
      r_next_grant <= '0;
      r_chain      <= 1'b0;
`endif
    end else begin
      // Shifter clear is released on the first edge after reset.
      piso_clr  <= 1'b0;
      // Single-cycle strobes default low.
      piso_load <= 1'b0;
      req_ack   <= '0;
      req_done  <= '0;
      tx_last   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en && w_win_any) begin
            grant     <= w_win_oh;
            piso_din  <= w_win_data;
            piso_load <= 1'b1;
            req_ack   <= w_win_oh;
            r_rr_ptr  <= w_next_ptr;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Shifter captures piso_din on this edge; bit 31 follows.
          r_state  <= S_SHIFT;
          bit_cnt  <= 5'd31;
          tx_valid <= 1'b1;
        end
        S_SHIFT: begin
          if (bit_cnt != 5'd0) begin
            bit_cnt <= bit_cnt - 5'd1;
            if (bit_cnt == 5'd1) begin
              // Entering the last bit time.
              tx_last  <= 1'b1;
              req_done <= grant;
`ifdef PISO_SCHED_B2B_EN
              if (en && w_win_any) begin
                r_next_grant <= w_win_oh;
                piso_din     <= w_win_data;
                piso_load    <= 1'b1;
                req_ack      <= w_win_oh;
                r_rr_ptr     <= w_next_ptr;
                r_chain      <= 1'b1;
              end
`endif
            end
          end else begin
`ifdef PISO_SCHED_B2B_EN
            if (r_chain) begin
              // Shifter loads the chained word on this edge: no gap.
              grant   <= r_next_grant;
              bit_cnt <= 5'd31;
              r_chain <= 1'b0;
            end else begin
              r_state  <= S_IDLE;
              tx_valid <= 1'b0;
              grant    <= '0;
            end
`else
            r_state  <= S_IDLE;
            tx_valid <= 1'b0;
            grant    <= '0;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_tx_scheduler
// Purpose  : Self-checking bench for piso_tx_scheduler. A behavioural model
//            tracks the frame owner and the bit time since the grant edge,
//            and from that predicts every scheduler output cycle by cycle.
//            A bench-side shifter turns piso_* into the serial line, which is
//            checked against the granted word MSB-first.
//            Honours `PISO_SCHED_B2B_EN in the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_tx_scheduler;

  localparam int NREQ = 4;
`ifdef PISO_SCHED_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic                clk_out;
  logic                reset;
  logic                en;
  logic [NREQ-1:0]     req_valid;
  logic [32*NREQ-1:0]  req_data;
  logic [NREQ-1:0]     req_ack;
  logic [NREQ-1:0]     req_done;
  logic [31:0]         piso_din;
  logic                piso_load;
  logic                piso_clr;
  logic                tx_valid;
  logic                tx_last;
  logic [4:0]          bit_cnt;
  logic [NREQ-1:0]     grant;
  logic                busy;

  piso_tx_scheduler #(.NREQ(NREQ)) dut (
    .clk_out   (clk_out),
    .reset     (reset),
    .en        (en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .req_done  (req_done),
    .piso_din  (piso_din),
    .piso_load (piso_load),
    .piso_clr  (piso_clr),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .bit_cnt   (bit_cnt),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  // Serial shifter as it sits next to the scheduler; dout = sh_reg[31].
  logic [31:0] sh_reg;
  always @(posedge clk_out) begin
    if (piso_clr)       sh_reg <= '0;
    else if (piso_load) sh_reg <= piso_din;
    else                sh_reg <= {sh_reg[30:0], 1'b0};
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_owner: requester owning the frame (-1 none); m_age: edges since grant.
  // age 0 = load cycle, age a in 1..32 = bit (32-a) on the line.
  int          m_owner, m_pend, m_age, m_ptr;
  logic [31:0] m_word, m_pend_word;
  bit          m_clr;

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (v[i]) begin
        m_ptr = (i + 1) % NREQ;
        return i;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_pend = -1; m_age = 0; m_ptr = 0; m_clr = 1'b1;
    m_word = '0; m_pend_word = '0;
  endtask

  task automatic model_edge(input logic [NREQ-1:0] v, input logic e, input logic r,
                            input logic [32*NREQ-1:0] d);
    if (!r) begin
      model_reset();
      return;
    end
    m_clr = 1'b0;
    if (m_owner < 0) begin
      if (e && (v != '0)) begin
        m_owner = pick(v);
        m_word  = d[32*m_owner +: 32];
        m_age   = 0;
      end
    end else begin
      m_age++;
      if (m_age == 33) begin
        if (m_pend >= 0) begin
          m_owner = m_pend; m_word = m_pend_word; m_pend = -1; m_age = 1;
        end else begin
          m_owner = -1; m_age = 0;
        end
      end else if (m_age == 32 && B2B && e && (v != '0)) begin
        m_pend      = pick(v);
        m_pend_word = d[32*m_pend +: 32];
      end
    end
  endtask

  function automatic logic [NREQ-1:0] exp_ack();
    if (m_owner >= 0 && m_age == 0)  return oh(m_owner);
    if (m_pend >= 0 && m_age == 32)  return oh(m_pend);
    return '0;
  endfunction

  task automatic check_outputs();
    logic [NREQ-1:0] g;
    bit tv, ld, last;
    g    = (m_owner >= 0) ? oh(m_owner) : '0;
    tv   = (m_owner >= 0) && (m_age >= 1);
    last = tv && (m_age == 32);
    ld   = ((m_owner >= 0) && (m_age == 0)) || ((m_pend >= 0) && (m_age == 32));
    chk("busy",      32'(busy),      32'(m_owner >= 0));
    chk("grant",     32'(grant),     32'(g));
    chk("tx_valid",  32'(tx_valid),  32'(tv));
    chk("bit_cnt",   32'(bit_cnt),   tv ? 32'(32 - m_age) : 32'd0);
    chk("tx_last",   32'(tx_last),   32'(last));
    chk("req_done",  32'(req_done),  last ? 32'(g) : 32'd0);
    chk("req_ack",   32'(req_ack),   32'(exp_ack()));
    chk("piso_load", 32'(piso_load), 32'(ld));
    chk("piso_clr",  32'(piso_clr),  32'(m_clr));
    if (ld) chk("piso_din", piso_din, (m_age == 0) ? m_word : m_pend_word);
    if (!reset) chk("piso_din_rst", piso_din, 32'd0);
    if (tv) chk("dout", 32'(sh_reg[31]), 32'(m_word[32 - m_age]));
  endtask

  // ---------------- requesters ----------------
  logic [NREQ-1:0] keep_mask;
  bit              rand_keep, auto_raise;
  int              ack_log[$];

  task automatic requesters_update();
    logic [NREQ-1:0] a;
    a = exp_ack();
    for (int i = 0; i < NREQ; i++) begin
      if (a[i]) begin
        if (keep_mask[i]) req_data[32*i +: 32] = $urandom();
        else              req_valid[i] = 1'b0;
        if (rand_keep) keep_mask[i] = 1'($urandom_range(0, 1));
      end else if (auto_raise && !req_valid[i] && $urandom_range(0, 15) == 0) begin
        req_valid[i] = 1'b1;
        req_data[32*i +: 32] = $urandom();
      end
    end
  endtask

  task automatic step();
    logic [NREQ-1:0]    v;
    logic               e, r;
    logic [32*NREQ-1:0] d;
    v = req_valid; e = en; r = reset; d = req_data;
    @(posedge clk_out);
    #1;
    model_edge(v, e, r, d);
    check_outputs();
    if (req_ack != '0)
      for (int i = NREQ - 1; i >= 0; i--) if (req_ack[i]) ack_log.push_back(i);
    requesters_update();
  endtask

  task automatic run_until_idle(input int limit);
    for (int k = 0; k < limit; k++) begin
      step();
      if (m_owner < 0) return;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic wait_bitcnt(input int b);
    for (int k = 0; k < 120; k++) begin
      step();
      if (m_owner >= 0 && m_age >= 1 && (32 - m_age) == b) return;
    end
    chk("bitcnt_reached", 32'(bit_cnt), 32'(b));
  endtask

  task automatic wait_ack(output int idx);
    idx = -1;
    for (int k = 0; k < 120; k++) begin
      step();
      if (req_ack != '0) begin
        for (int i = NREQ - 1; i >= 0; i--) if (req_ack[i]) idx = i;
        return;
      end
    end
    chk("ack_seen", 32'(req_ack != '0), 32'd1);
  endtask

  task automatic async_reset_pulse();
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) step();
    chk("shifter_cleared", sh_reg, 32'd0);
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    reset = 1'b1; en = 1'b0; req_valid = '0; req_data = '0;
    keep_mask = '0; rand_keep = 1'b0; auto_raise = 1'b0;
    model_reset();
    #1 reset = 1'b0;
    #1;
    check_outputs();
    repeat (2) step();
    reset = 1'b1;

    // Single word from requester 0; alternating MSB pattern on the line.
    req_data[31:0] = 32'hA5A5_0F0F;
    req_valid[0]   = 1'b1;
    en             = 1'b1;
    step();
    chk("t1_ack0", 32'(req_ack), 32'h1);
    run_until_idle(60);
    repeat (3) step();

    // All requesters held valid: rotation continues from pointer 1.
    for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = $urandom();
    keep_mask = '1;
    req_valid = '1;
    ack_log.delete();
    for (int k = 0; k < 400 && ack_log.size() < 5; k++) step();
    for (int k = 0; k < 5; k++)
      chk("rr_order", (k < ack_log.size()) ? 32'(ack_log[k]) : 32'hFFFF_FFFF,
          32'((1 + k) % NREQ));
    keep_mask = '0;
    req_valid = '0;
    run_until_idle(80);
    repeat (2) step();

    // en falls mid-frame with requester 1 pending.
    req_valid[0] = 1'b1;
    req_data[31:0] = $urandom();
    wait_bitcnt(10);
    en = 1'b0;
    req_valid[1] = 1'b1;
    req_data[63:32] = $urandom();
    run_until_idle(40);
    repeat (4) step();
    chk("en0_busy", 32'(busy), 32'd0);
    en = 1'b1;
    step();
    chk("en1_grant1", 32'(req_ack), 32'h2);
    run_until_idle(60);

    // Reset in the middle of a frame.
    req_valid[3] = 1'b1;
    req_data[127:96] = $urandom();
    wait_bitcnt(15);
    req_valid = '0;
    async_reset_pulse();
    step();
    chk("clr_released", 32'(piso_clr), 32'd0);

    // Requester 2 alone for three words, then requester 0 wins via wrap.
    keep_mask[2] = 1'b1;
    req_valid[2] = 1'b1;
    req_data[95:64] = $urandom();
    for (int n = 0; n < 3; n++) begin
      wait_ack(w);
      chk("t5_req2", 32'(w), 32'd2);
    end
    keep_mask = '0;
    req_valid[2] = 1'b0;
    req_valid[0] = 1'b1;
    req_data[31:0] = $urandom();
    wait_ack(w);
    chk("t5_wrap0", 32'(w), 32'd0);
    for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = $urandom();
    req_valid = '1;
    wait_ack(w);
    chk("t5_ptr1", 32'(w), 32'd1);

    // Randomised traffic with en toggling and one reset pulse.
    rand_keep = 1'b1;
    auto_raise = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 63) == 0) en = ~en;
      if (c == 1500) async_reset_pulse();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
